// File: rtl/free_list.sv
// rtl/free_list.sv - rename free list: 2-wide pop/push circular FIFO of preg IDs with checkpointed head
module free_list #(
   parameter int P_ADDR_WIDTH = 7,
   parameter int L_ADDR_WIDTH = 5,
   parameter int C_NUM        = 2
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        pop_1,
   input  logic                        pop_2,
   output logic [P_ADDR_WIDTH-1:0]     alloc_data_1,
   output logic [P_ADDR_WIDTH-1:0]     alloc_data_2,
   output logic                        stall,
   output logic [P_ADDR_WIDTH:0]       free_count,
   input  logic                        push_1,
   input  logic [P_ADDR_WIDTH-1:0]     release_data_1,
   input  logic                        push_2,
   input  logic [P_ADDR_WIDTH-1:0]     release_data_2,
   input  logic                        take_checkpoint,
   input  logic                        instr_num,
   input  logic                        dual_branch,
   output logic [$clog2(C_NUM)-1:0]    current_id,
   input  logic                        restore,
   input  logic [$clog2(C_NUM)-1:0]    restore_id
);

   localparam int DEPTH = 2**P_ADDR_WIDTH;
   localparam int NFREE = DEPTH - 2**L_ADDR_WIDTH;
   localparam int CW    = $clog2(C_NUM);

   typedef logic [P_ADDR_WIDTH-1:0] ptr_t;

   ptr_t            fifo [DEPTH];
   ptr_t            ckp  [C_NUM];
   ptr_t            head;
   ptr_t            tail;
   logic [CW-1:0]   next_ckp;

   logic [1:0]      npop;
   logic [1:0]      npush;
   ptr_t            head_pop1;
   ptr_t            head_npop;
   ptr_t            tail_2;
   logic            ckp_en;

   assign npop      = {1'b0, pop_1} + {1'b0, pop_2};
   assign npush     = {1'b0, push_1} + {1'b0, push_2};
   assign head_pop1 = head + ptr_t'(pop_1);
   assign head_npop = head + ptr_t'(npop);
   assign tail_2    = tail + ptr_t'(push_1);

   // Occupancy stays below DEPTH, so the modular difference is the exact count.
   assign free_count   = {1'b0, ptr_t'(tail - head)};
   assign stall        = ({{(P_ADDR_WIDTH-1){1'b0}}, npop} > free_count);
   assign alloc_data_1 = fifo[head];
   assign alloc_data_2 = pop_1 ? fifo[head + ptr_t'(1)] : fifo[head];
   assign ckp_en       = take_checkpoint && !stall && !restore;
   assign current_id   = next_ckp;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++)
            fifo[i] <= (i < NFREE) ? ptr_t'(i + 2**L_ADDR_WIDTH) : '0;
         for (int j = 0; j < C_NUM; j++)
            ckp[j] <= '0;
         head     <= '0;
         tail     <= ptr_t'(NFREE);
         next_ckp <= '0;
      end else begin
         // Pushes compact into consecutive slots and are never blocked.
         if (push_1)
            fifo[tail] <= release_data_1;
         if (push_2)
            fifo[tail_2] <= release_data_2;
         tail <= tail + ptr_t'(npush);

         if (restore)
            head <= ckp[restore_id];
         else if (!stall)
            head <= head_npop;

         if (ckp_en) begin
            if (dual_branch) begin
               ckp[next_ckp]            <= head_pop1;
               ckp[next_ckp + CW'(1)]   <= head_npop;
               next_ckp                 <= next_ckp + CW'(2);
            end else begin
               ckp[next_ckp] <= instr_num ? head_npop : head_pop1;
               next_ckp      <= next_ckp + CW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_free_list.sv
// tb/tb_free_list.sv - self-checking bench for free_list against a counter-based free-list model
module tb_free_list;

   localparam int P = 7;
   localparam int C = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         pop_1, pop_2;
   logic [P-1:0] alloc_data_1, alloc_data_2;
   logic         stall;
   logic [P:0]   free_count;
   logic         push_1, push_2;
   logic [P-1:0] release_data_1, release_data_2;
   logic         take_checkpoint, instr_num, dual_branch;
   logic [0:0]   current_id;
   logic         restore;
   logic [0:0]   restore_id;

   int n_checks = 0;
   int n_pass   = 0;

   free_list dut (
      .clk(clk), .rst(rst),
      .pop_1(pop_1), .pop_2(pop_2),
      .alloc_data_1(alloc_data_1), .alloc_data_2(alloc_data_2),
      .stall(stall), .free_count(free_count),
      .push_1(push_1), .release_data_1(release_data_1),
      .push_2(push_2), .release_data_2(release_data_2),
      .take_checkpoint(take_checkpoint), .instr_num(instr_num), .dual_branch(dual_branch),
      .current_id(current_id),
      .restore(restore), .restore_id(restore_id)
   );

   always #5 clk = ~clk;

   // Model: unbounded allocate/release counters over a 128-slot ring of preg IDs.
   int m_mem [128];
   int m_head, m_tail;
   int m_ckp [C];
   int m_nc;
   int inflight [$];

   function automatic void model_reset();
      for (int i = 0; i < 128; i++) m_mem[i] = (i < 96) ? i + 32 : 0;
      m_head = 0;
      m_tail = 96;
      for (int i = 0; i < C; i++) m_ckp[i] = 0;
      m_nc = 0;
      inflight.delete();
   endfunction

   function automatic int m_count();
      return m_tail - m_head;
   endfunction

   function automatic int m_at(int off);
      return m_mem[(m_head + off) % 128];
   endfunction

   function automatic void model_edge();
      int np;
      bit st;
      np = int'(pop_1) + int'(pop_2);
      st = np > m_count();
      if (take_checkpoint && !st && !restore) begin
         if (dual_branch) begin
            m_ckp[m_nc]           = m_head + int'(pop_1);
            m_ckp[(m_nc + 1) % C] = m_head + np;
            m_nc                  = (m_nc + 2) % C;
         end else begin
            m_ckp[m_nc] = m_head + (instr_num ? np : int'(pop_1));
            m_nc        = (m_nc + 1) % C;
         end
      end
      if (restore) begin
         m_head = m_ckp[restore_id];
      end else if (!st) begin
         if (pop_1) inflight.push_back(m_at(0));
         if (pop_2) inflight.push_back(m_at(int'(pop_1)));
         m_head = m_head + np;
      end
      if (push_1) begin m_mem[m_tail % 128] = int'(release_data_1); m_tail++; end
      if (push_2) begin m_mem[m_tail % 128] = int'(release_data_2); m_tail++; end
   endfunction

   task automatic clear_inputs();
      pop_1 = 0; pop_2 = 0; push_1 = 0; push_2 = 0;
      release_data_1 = '0; release_data_2 = '0;
      take_checkpoint = 0; instr_num = 0; dual_branch = 0;
      restore = 0; restore_id = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1;
      model_reset();
      @(posedge clk);
      #1 rst = 0;
   endtask

   task automatic pop_cycles(int n, logic p1, logic p2);
      pop_1 = p1; pop_2 = p2;
      repeat (n) tick();
      pop_1 = 0; pop_2 = 0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      n_checks++; if (free_count !== 96) $display("FAIL reset_free_count got %0d exp 96", free_count); else n_pass++;
      n_checks++; if (alloc_data_1 !== 32) $display("FAIL reset_alloc1 got %0d exp 32", alloc_data_1); else n_pass++;
      n_checks++; if (alloc_data_2 !== 32) $display("FAIL reset_alloc2_nopop1 got %0d exp 32", alloc_data_2); else n_pass++;
      n_checks++; if (current_id !== 0) $display("FAIL reset_current_id got %0d exp 0", current_id); else n_pass++;
      n_checks++; if (stall !== 0) $display("FAIL reset_stall got %0d exp 0", stall); else n_pass++;
      pop_1 = 1;
      #1;
      n_checks++; if (alloc_data_2 !== 33) $display("FAIL reset_alloc2_pop1 got %0d exp 33", alloc_data_2); else n_pass++;
      pop_1 = 0;
   endtask

   task automatic test_pop_pairs();
      do_reset();
      pop_1 = 1; pop_2 = 1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         n_checks++; if (alloc_data_1 !== P'(32 + 2*c)) $display("FAIL pair_alloc1[%0d] got %0d exp %0d", c, alloc_data_1, 32 + 2*c); else n_pass++;
         n_checks++; if (alloc_data_2 !== P'(33 + 2*c)) $display("FAIL pair_alloc2[%0d] got %0d exp %0d", c, alloc_data_2, 33 + 2*c); else n_pass++;
         n_checks++; if (free_count !== (P+1)'(96 - 2*c)) $display("FAIL pair_count[%0d] got %0d exp %0d", c, free_count, 96 - 2*c); else n_pass++;
         tick();
      end
      clear_inputs();
      @(negedge clk);
      n_checks++; if (free_count !== 92) $display("FAIL pair_count_end got %0d exp 92", free_count); else n_pass++;
   endtask

   task automatic test_stall();
      do_reset();
      pop_cycles(47, 1, 1);
      pop_cycles(1, 1, 0);
      @(negedge clk);
      n_checks++; if (free_count !== 1) $display("FAIL stall_drain_count got %0d exp 1", free_count); else n_pass++;
      pop_1 = 1; pop_2 = 1; take_checkpoint = 1;
      #1;
      n_checks++; if (stall !== 1) $display("FAIL stall_assert got %0d exp 1", stall); else n_pass++;
      tick();
      clear_inputs();
      @(negedge clk);
      n_checks++; if (free_count !== 1) $display("FAIL stall_hold_count got %0d exp 1", free_count); else n_pass++;
      n_checks++; if (alloc_data_1 !== 127) $display("FAIL stall_hold_head got %0d exp 127", alloc_data_1); else n_pass++;
      n_checks++; if (current_id !== 0) $display("FAIL stall_ckp_ignored got %0d exp 0", current_id); else n_pass++;
      pop_2 = 1;
      #1;
      n_checks++; if (stall !== 0) $display("FAIL stall_exact_fit got %0d exp 0", stall); else n_pass++;
      n_checks++; if (alloc_data_2 !== 127) $display("FAIL stall_pop2_grant got %0d exp 127", alloc_data_2); else n_pass++;
      tick();
      @(negedge clk);
      n_checks++; if (free_count !== 0) $display("FAIL stall_empty_count got %0d exp 0", free_count); else n_pass++;
      n_checks++; if (stall !== 1) $display("FAIL stall_empty_pop2 got %0d exp 1", stall); else n_pass++;
      clear_inputs();
   endtask

   task automatic test_checkpoint_restore();
      do_reset();
      pop_cycles(5, 1, 1);
      @(negedge clk);
      n_checks++; if (alloc_data_1 !== 42) $display("FAIL ckp_head10 got %0d exp 42", alloc_data_1); else n_pass++;
      take_checkpoint = 1; instr_num = 1; pop_1 = 1; pop_2 = 1;
      tick();
      clear_inputs();
      @(negedge clk);
      n_checks++; if (current_id !== 1) $display("FAIL ckp_current_id got %0d exp 1", current_id); else n_pass++;
      pop_cycles(3, 1, 1);
      restore = 1; restore_id = 0;
      tick();
      clear_inputs();
      @(negedge clk);
      n_checks++; if (alloc_data_1 !== 44) $display("FAIL restore_alloc1 got %0d exp 44", alloc_data_1); else n_pass++;
      n_checks++; if (free_count !== 84) $display("FAIL restore_count got %0d exp 84", free_count); else n_pass++;
      n_checks++; if (current_id !== 1) $display("FAIL restore_id_held got %0d exp 1", current_id); else n_pass++;
   endtask

   task automatic test_dual_branch();
      do_reset();
      take_checkpoint = 1; dual_branch = 1; pop_1 = 1; pop_2 = 1;
      tick();
      clear_inputs();
      @(negedge clk);
      n_checks++; if (current_id !== 0) $display("FAIL dual_id_wrap got %0d exp 0", current_id); else n_pass++;
      pop_cycles(2, 1, 1);
      // Preg 32 precedes both branches, so releasing it during the restore is legal.
      restore = 1; restore_id = 1; push_1 = 1; release_data_1 = 32;
      tick();
      clear_inputs();
      @(negedge clk);
      n_checks++; if (alloc_data_1 !== 34) $display("FAIL dual_restore1_alloc got %0d exp 34", alloc_data_1); else n_pass++;
      n_checks++; if (free_count !== 95) $display("FAIL dual_restore1_count got %0d exp 95", free_count); else n_pass++;
      restore = 1; restore_id = 0;
      tick();
      clear_inputs();
      @(negedge clk);
      n_checks++; if (alloc_data_1 !== 33) $display("FAIL dual_restore0_alloc got %0d exp 33", alloc_data_1); else n_pass++;
      n_checks++; if (free_count !== 96) $display("FAIL dual_restore0_count got %0d exp 96", free_count); else n_pass++;
   endtask

   task automatic random_cycle(int c);
      int n;
      clear_inputs();
      pop_1 = 1'($urandom);
      pop_2 = 1'($urandom);
      take_checkpoint = ($urandom_range(0, 7) == 0);
      dual_branch = 1'($urandom);
      instr_num = 1'($urandom);
      n = $urandom_range(0, 2);
      if (n > inflight.size()) n = inflight.size();
      if (n == 2) begin
         push_1 = 1; release_data_1 = P'(inflight.pop_front());
         push_2 = 1; release_data_2 = P'(inflight.pop_front());
      end else if (n == 1) begin
         if ($urandom_range(0, 1) == 0) begin push_1 = 1; release_data_1 = P'(inflight.pop_front()); end
         else begin push_2 = 1; release_data_2 = P'(inflight.pop_front()); end
      end
      @(negedge clk);
      n_checks++; if (free_count !== (P+1)'(m_count())) $display("FAIL rnd_count[%0d] got %0d exp %0d", c, free_count, m_count()); else n_pass++;
      n_checks++; if (stall !== (int'(pop_1) + int'(pop_2) > m_count())) $display("FAIL rnd_stall[%0d] got %0d exp %0d", c, stall, int'(pop_1) + int'(pop_2) > m_count()); else n_pass++;
      n_checks++; if (current_id !== 1'(m_nc)) $display("FAIL rnd_current_id[%0d] got %0d exp %0d", c, current_id, m_nc); else n_pass++;
      if (m_count() > 0) begin
         n_checks++; if (alloc_data_1 !== P'(m_at(0))) $display("FAIL rnd_alloc1[%0d] got %0d exp %0d", c, alloc_data_1, m_at(0)); else n_pass++;
      end
      if (m_count() > int'(pop_1)) begin
         n_checks++; if (alloc_data_2 !== P'(m_at(int'(pop_1)))) $display("FAIL rnd_alloc2[%0d] got %0d exp %0d", c, alloc_data_2, m_at(int'(pop_1))); else n_pass++;
      end
      tick();
   endtask

   task automatic test_push_wrap();
      do_reset();
      for (int c = 0; c < 400; c++) random_cycle(c);
      clear_inputs();
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 20; c++) random_cycle(400 + c);
      pop_1 = 1; pop_2 = 1; push_1 = 0; push_2 = 0; take_checkpoint = 0;
      @(posedge clk);
      #2 rst = 1;
      #1;
      n_checks++; if (free_count !== 96) $display("FAIL midrst_count got %0d exp 96", free_count); else n_pass++;
      n_checks++; if (alloc_data_1 !== 32) $display("FAIL midrst_alloc1 got %0d exp 32", alloc_data_1); else n_pass++;
      n_checks++; if (alloc_data_2 !== 33) $display("FAIL midrst_alloc2 got %0d exp 33", alloc_data_2); else n_pass++;
      n_checks++; if (current_id !== 0) $display("FAIL midrst_current_id got %0d exp 0", current_id); else n_pass++;
      n_checks++; if (stall !== 0) $display("FAIL midrst_stall got %0d exp 0", stall); else n_pass++;
      clear_inputs();
      model_reset();
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      n_checks++; if (free_count !== 96) $display("FAIL midrst_release_count got %0d exp 96", free_count); else n_pass++;
   endtask

   initial begin
      clear_inputs();
      rst = 1;
      model_reset();
      test_reset();
      test_pop_pairs();
      test_stall();
      test_checkpoint_restore();
      test_dual_branch();
      test_push_wrap();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
